bios_ram_loader: RTL and testbench
==================================

// Module: bios_ram_loader
// PURPOSE
//  Writable counterpart of the fixed BIOS ROM: receives a BIOS image as a byte stream
//  (e.g. from the UART receive path) and writes it into a 2^ADDR_WIDTH x 32 shadow RAM.
//  The CPU fetch side then reads the RAM through the same address/romData interface the ROM uses.
//  Image format: word count N, then N data words (word 0 = MAGIC), then a checksum word.
//  All words are sent MSB byte first.
// PARAMETERS
//  ADDR_WIDTH  11            word address width; RAM depth = 2^ADDR_WIDTH
//  MAGIC       32'hDEADBEEF  required value of data word 0
//  BYTE_SWAP   1             1: store words byte-reversed (DEADBEEF -> EFBEADDE), as the fetch path expects
// PORTS
//  clock      in   1           single clock domain, rising edge
//  reset      in   1           synchronous, active-high
//  start      in   1           begin a load; sampled only when busy=0
//  byteValid  in   1           stream byte valid
//  byteData   in   8           stream byte
//  byteReady  out  1           loader accepts byte; transfer when byteValid & byteReady
//  address    in   ADDR_WIDTH  CPU read word address
//  romData    out  32          read data, registered, 1-cycle latency
//  busy       out  1           load in progress
//  done       out  1           last load succeeded; held until next start or reset
//  error      out  1           last load failed; held until next start or reset
//  errorCode  out  2           0 none, 1 bad length, 2 bad magic, 3 checksum mismatch
//  wordCount  out  ADDR_WIDTH+1  number of valid words in RAM (0 if none)
// BEHAVIOUR
//  - Reset: state IDLE; byteReady=0, busy=0, done=0, error=0, errorCode=0, wordCount=0, romData=0.
//    RAM contents are not reset; reads are gated by wordCount instead.
//  - FSM states: IDLE, LEN, DATA, SUM, DONE, ERR.
//    - IDLE/DONE/ERR, start=1 -> LEN. On this transition: clear done, error, errorCode,
//      wordCount, the checksum accumulator and the byte and word counters.
//    - start is ignored in LEN, DATA and SUM.
//    - LEN: assemble 4 bytes into N. If N==0 or N>2^ADDR_WIDTH -> ERR (code 1); else -> DATA.
//    - DATA: every 4th accepted byte completes a word w.
//      - Write w (byte-swapped if BYTE_SWAP) to RAM[wordIdx] on the next edge.
//      - Add w (unswapped) to the accumulator, modulo 2^32.
//      - If wordIdx==0 and w!=MAGIC -> ERR (code 2); the word is not counted as valid.
//      - When wordIdx==N-1 completes -> SUM.
//    - SUM: assemble 4 bytes. Equal to accumulator -> DONE (wordCount=N, done=1);
//      else -> ERR (code 3, wordCount stays 0).
//  - byteReady = 1 only in LEN, DATA and SUM (a registered state decode). It is 0 in the cycle
//    after the byte that causes an ERR/DONE transition. busy = state in {LEN, DATA, SUM}.
//  - done/error assert the cycle after the final (or offending) byte is accepted.
//  - byteValid may drop at any time; partial-word byte position is retained across gaps.
//  - Read port: romData <= (!busy && address < wordCount) ? RAM[address] : 32'd0,
//    registered one cycle after address.
//    - Reads during a load return 0.
//    - Reads beyond the image return 0, matching ROM default behaviour.
//  - Reset mid-load: return to IDLE with wordCount=0. No partial image is ever visible.
//  - Accumulator and counters are sized so that N = 2^ADDR_WIDTH does not wrap wordIdx
//    before the SUM transition.
// TESTING
//  1. Good load: start; bytes 00 00 00 02 | DE AD BE EF | 00 00 00 15 | DE AD BF 04
//     -> done=1, wordCount=2; addr0 -> EFBEADDE, addr1 -> 15000000, addr2 -> 00000000.
//  2. Bad magic: N=1, data DE AD BE EE -> error=1, errorCode=2, byteReady=0 next cycle, wordCount=0.
//  3. Bad length: N=0 -> errorCode=1. New start, N=0x00000801 (ADDR_WIDTH=11) -> errorCode=1.
//     N=0x800 full image with correct sum -> done, last address readable.
//  4. Checksum mismatch: test 1 image with sum DE AD BF 05 -> errorCode=3; all reads return 0.
//  5. Random byteValid gaps on test 1 -> identical result.
//     Reset asserted mid-DATA -> busy=0, byteReady=0, reads 0; subsequent clean load succeeds.
//  6. Pulse start while busy -> no restart, load completes normally.
//     Read addr0 during load -> 0; after done -> EFBEADDE, one cycle after address is applied.

Source files
------------

// File: rtl/bios_ram_loader.sv
// bios_ram_loader: receives a BIOS image as a byte stream and writes it into a
// shadow RAM. The RAM is then read through a ROM-compatible address/romData port.
// Image layout on the stream is: word count N, N data words (word 0 must be MAGIC),
// then a checksum word. Every word arrives MSB byte first.
module bios_ram_loader #(
  parameter int          ADDR_WIDTH = 11,
  parameter logic [31:0] MAGIC      = 32'hDEADBEEF,
  parameter bit          BYTE_SWAP  = 1'b1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  byteValid,
  input  logic [7:0]            byteData,
  output logic                  byteReady,
  input  logic [ADDR_WIDTH-1:0] address,
  output logic [31:0]           romData,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [1:0]            errorCode,
  output logic [ADDR_WIDTH:0]   wordCount
);

  localparam int          DEPTH     = 1 << ADDR_WIDTH;
  localparam logic [31:0] MAX_WORDS = 32'(DEPTH);

  typedef enum logic [2:0] {
    IDLE,
    LEN,
    DATA,
    SUM,
    DONE,
    ERR
  } state_t;

  state_t                r_state;
  logic [23:0]           r_shift;
  logic [1:0]            r_bytePos;
  logic [ADDR_WIDTH:0]   r_n;
  logic [ADDR_WIDTH:0]   r_wordIdx;
  logic [31:0]           r_acc;
  logic                  r_byteReady;
  logic                  r_busy;
  logic                  r_done;
  logic                  r_error;
  logic [1:0]            r_errorCode;
  logic [ADDR_WIDTH:0]   r_wordCount;
  logic                  r_wrEn;
  logic [ADDR_WIDTH-1:0] r_wrAddr;
  logic [31:0]           r_wrData;
  logic [31:0]           r_romData;
  logic [31:0]           r_mem [DEPTH];

  logic                  w_accept;
  logic                  w_wordDone;
  logic [31:0]           w_word;
  logic [31:0]           w_stored;
  logic [ADDR_WIDTH:0]   w_lastIdx;

  assign w_accept   = byteValid & r_byteReady;
  assign w_wordDone = w_accept && (r_bytePos == 2'd3);
  assign w_word     = {r_shift, byteData};
  assign w_stored   = BYTE_SWAP ? {w_word[7:0], w_word[15:8], w_word[23:16], w_word[31:24]}
                                : w_word;
  assign w_lastIdx  = r_n - {{ADDR_WIDTH{1'b0}}, 1'b1};

  // Load sequencer: byte assembly, length/magic/checksum checks and status flags
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state     <= IDLE;
      r_shift     <= '0;
      r_bytePos   <= '0;
      r_n         <= '0;
      r_wordIdx   <= '0;
      r_acc       <= '0;
      r_byteReady <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_error     <= 1'b0;
      r_errorCode <= 2'd0;
      r_wordCount <= '0;
      r_wrEn      <= 1'b0;
      r_wrAddr    <= '0;
      r_wrData    <= '0;
    end else begin
      r_wrEn <= 1'b0;
      if (w_accept) begin
        r_shift   <= {r_shift[15:0], byteData};
        r_bytePos <= r_bytePos + 2'd1;
      end
      case (r_state)
        LEN: begin
          if (w_wordDone) begin
            if (w_word == 32'd0 || w_word > MAX_WORDS) begin
              r_state     <= ERR;
              r_byteReady <= 1'b0;
              r_busy      <= 1'b0;
              r_error     <= 1'b1;
              r_errorCode <= 2'd1;
            end else begin
              r_state <= DATA;
              r_n     <= w_word[ADDR_WIDTH:0];
            end
          end
        end
        DATA: begin
          if (w_wordDone) begin
            r_wrEn    <= 1'b1;
            r_wrAddr  <= r_wordIdx[ADDR_WIDTH-1:0];
            r_wrData  <= w_stored;
            r_acc     <= r_acc + w_word;
            r_wordIdx <= r_wordIdx + 1'b1;
            if (r_wordIdx == '0 && w_word != MAGIC) begin
              r_state     <= ERR;
              r_byteReady <= 1'b0;
              r_busy      <= 1'b0;
              r_error     <= 1'b1;
              r_errorCode <= 2'd2;
            end else if (r_wordIdx == w_lastIdx) begin
              r_state <= SUM;
            end
          end
        end
        SUM: begin
          if (w_wordDone) begin
            r_byteReady <= 1'b0;
            r_busy      <= 1'b0;
            if (w_word == r_acc) begin
              r_state     <= DONE;
              r_done      <= 1'b1;
              r_wordCount <= r_n;
            end else begin
              r_state     <= ERR;
              r_error     <= 1'b1;
              r_errorCode <= 2'd3;
            end
          end
        end
        default: begin
          if (start) begin
            r_state     <= LEN;
            r_byteReady <= 1'b1;
            r_busy      <= 1'b1;
            r_done      <= 1'b0;
            r_error     <= 1'b0;
            r_errorCode <= 2'd0;
            r_wordCount <= '0;
            r_acc       <= '0;
            r_bytePos   <= '0;
            r_wordIdx   <= '0;
          end
        end
      endcase
    end
  end

  // Shadow RAM write port; contents are never reset, visibility is gated by wordCount
  always_ff @(posedge clock) begin
    if (r_wrEn) begin
      r_mem[r_wrAddr] <= r_wrData;
    end
  end

  // Registered read port; returns zero while loading or beyond the valid image
  always_ff @(posedge clock) begin
    if (reset) begin
      r_romData <= '0;
    end else if (!r_busy && ({1'b0, address} < r_wordCount)) begin
      r_romData <= r_mem[address];
    end else begin
      r_romData <= '0;
    end
  end

  assign byteReady = r_byteReady;
  assign busy      = r_busy;
  assign done      = r_done;
  assign error     = r_error;
  assign errorCode = r_errorCode;
  assign wordCount = r_wordCount;
  assign romData   = r_romData;

endmodule

// File: tb/tb_bios_ram_loader.sv
// tb_bios_ram_loader: directed scoreboard bench for the BIOS RAM loader.
module tb_bios_ram_loader;

  localparam int AW = 11;

  logic          clock = 1'b0;
  logic          reset;
  logic          start;
  logic          byteValid;
  logic [7:0]    byteData;
  logic          byteReady;
  logic [AW-1:0] address;
  logic [31:0]   romData;
  logic          busy;
  logic          done;
  logic          error;
  logic [1:0]    errorCode;
  logic [AW:0]   wordCount;

  int testCount = 0;
  int failCount = 0;
  bit gapMode   = 1'b0;

  typedef struct {
    string       tag;
    logic [31:0] exp;
  } exp_t;

  exp_t sbQueue[$];

  bios_ram_loader #(.ADDR_WIDTH(AW)) dut (
    .clock     (clock),
    .reset     (reset),
    .start     (start),
    .byteValid (byteValid),
    .byteData  (byteData),
    .byteReady (byteReady),
    .address   (address),
    .romData   (romData),
    .busy      (busy),
    .done      (done),
    .error     (error),
    .errorCode (errorCode),
    .wordCount (wordCount)
  );

  // Free-running 100 MHz clock
  always #5 clock = ~clock;

  function automatic logic [31:0] packStatus(input logic d, input logic e,
                                             input logic [1:0] c, input logic [AW:0] wc);
    return {16'd0, d, e, c, wc};
  endfunction

  function automatic logic [31:0] swapWord(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    testCount++;
    assert (observed === expected) else begin
      failCount++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic applyStimulus();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic sendByte(input logic [7:0] b);
    int n;
    if (gapMode) repeat ($urandom_range(2, 0)) tick();
    byteValid = 1'b1;
    byteData  = b;
    n = 0;
    while (!byteReady && n < 50) begin
      tick();
      n++;
    end
    if (!byteReady) begin
      checkOutput("byteTimeout", {31'd0, byteReady}, 32'd1);
      byteValid = 1'b0;
      return;
    end
    tick();
    byteValid = 1'b0;
  endtask

  task automatic sendWord(input logic [31:0] w);
    sendByte(w[31:24]);
    sendByte(w[23:16]);
    sendByte(w[15:8]);
    sendByte(w[7:0]);
  endtask

  task automatic pushStatus(input string tag, input logic d, input logic e,
                            input logic [1:0] c, input logic [AW:0] wc);
    sbQueue.push_back('{tag, packStatus(d, e, c, wc)});
  endtask

  task automatic popStatus();
    exp_t item;
    int n;
    n = 0;
    while (busy && n < 50) begin
      tick();
      n++;
    end
    if (sbQueue.size() == 0) begin
      checkOutput("sbEmpty", 32'(sbQueue.size()), 32'd1);
      return;
    end
    item = sbQueue.pop_front();
    checkOutput(item.tag, packStatus(done, error, errorCode, wordCount), item.exp);
  endtask

  task automatic readCheck(input string tag, input logic [AW-1:0] addr,
                           input logic [31:0] exp);
    exp_t item;
    address = addr;
    sbQueue.push_back('{tag, exp});
    tick();
    item = sbQueue.pop_front();
    checkOutput(item.tag, romData, item.exp);
  endtask

  task automatic goodImage(input string tag);
    applyStimulus();
    sendWord(32'd2);
    sendWord(32'hDEADBEEF);
    sendWord(32'h00000015);
    pushStatus(tag, 1'b1, 1'b0, 2'd0, 12'd2);
    sendWord(32'hDEADBF04);
    popStatus();
  endtask

  initial begin
    logic [31:0] sum;
    logic [31:0] w;
    logic [31:0] wLast;
    logic [31:0] wMid;

    reset     = 1'b1;
    start     = 1'b0;
    byteValid = 1'b0;
    byteData  = 8'd0;
    address   = '0;
    repeat (3) tick();
    reset = 1'b0;
    tick();

    checkOutput("resetStatus", packStatus(done, error, errorCode, wordCount), 32'd0);
    checkOutput("resetReady", {30'd0, busy, byteReady}, 32'd0);
    checkOutput("resetRom", romData, 32'd0);

    goodImage("goodLoad");
    readCheck("goodAddr0", 11'd0, 32'hEFBEADDE);
    readCheck("goodAddr1", 11'd1, 32'h15000000);
    readCheck("goodAddr2", 11'd2, 32'h00000000);

    applyStimulus();
    pushStatus("badMagic", 1'b0, 1'b1, 2'd2, 12'd0);
    sendWord(32'd1);
    sendWord(32'hDEADBEEE);
    checkOutput("badMagicReady", {31'd0, byteReady}, 32'd0);
    popStatus();
    readCheck("badMagicRead", 11'd0, 32'd0);

    applyStimulus();
    pushStatus("lenZero", 1'b0, 1'b1, 2'd1, 12'd0);
    sendWord(32'd0);
    checkOutput("lenZeroReady", {31'd0, byteReady}, 32'd0);
    popStatus();

    applyStimulus();
    pushStatus("lenTooBig", 1'b0, 1'b1, 2'd1, 12'd0);
    sendWord(32'h00000801);
    popStatus();

    applyStimulus();
    sendWord(32'h00000800);
    sum   = 32'd0;
    wLast = 32'd0;
    wMid  = 32'd0;
    for (int i = 0; i < 2048; i++) begin
      w = (i == 0) ? 32'hDEADBEEF : (32'(i) * 32'h9E3779B9);
      sum = sum + w;
      if (i == 2047) wLast = w;
      if (i == 1000) wMid = w;
      sendWord(w);
    end
    pushStatus("fullImage", 1'b1, 1'b0, 2'd0, 12'h800);
    sendWord(sum);
    popStatus();
    readCheck("fullLast", 11'd2047, swapWord(wLast));
    readCheck("fullMid", 11'd1000, swapWord(wMid));
    readCheck("fullAddr0", 11'd0, 32'hEFBEADDE);

    applyStimulus();
    sendWord(32'd2);
    sendWord(32'hDEADBEEF);
    sendWord(32'h00000015);
    pushStatus("badSum", 1'b0, 1'b1, 2'd3, 12'd0);
    sendWord(32'hDEADBF05);
    popStatus();
    readCheck("badSumAddr0", 11'd0, 32'd0);
    readCheck("badSumAddr1", 11'd1, 32'd0);

    gapMode = 1'b1;
    goodImage("gapLoad");
    gapMode = 1'b0;
    readCheck("gapAddr0", 11'd0, 32'hEFBEADDE);
    readCheck("gapAddr1", 11'd1, 32'h15000000);

    applyStimulus();
    sendWord(32'd2);
    sendWord(32'hDEADBEEF);
    sendByte(8'h00);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checkOutput("midResetFlags", {30'd0, busy, byteReady}, 32'd0);
    checkOutput("midResetStatus", packStatus(done, error, errorCode, wordCount), 32'd0);
    readCheck("midResetRead", 11'd0, 32'd0);
    goodImage("afterReset");
    readCheck("afterResetAddr1", 11'd1, 32'h15000000);

    applyStimulus();
    sendWord(32'd2);
    applyStimulus();
    checkOutput("startIgnored", {30'd0, busy, byteReady}, 32'd3);
    readCheck("readDuringLoad", 11'd0, 32'd0);
    sendWord(32'hDEADBEEF);
    sendByte(8'h00);
    applyStimulus();
    sendByte(8'h00);
    sendByte(8'h00);
    sendByte(8'h15);
    pushStatus("startWhileBusy", 1'b1, 1'b0, 2'd0, 12'd2);
    sendWord(32'hDEADBF04);
    popStatus();
    address = 11'd5;
    tick();
    address = 11'd0;
    checkOutput("latencyBefore", romData, 32'd0);
    tick();
    checkOutput("latencyAfter", romData, 32'hEFBEADDE);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
